// File: rtl/i2c_eeprom_pkg.sv
// ============================================================================
// Module   : i2c_eeprom_pkg
// Purpose  : Shared FSM states, address default and ACK levels for the
//            I2C EEPROM slave controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WADDR     = 4'd3,
    ST_WADDR_ACK = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RD_LOAD   = 4'd7,
    ST_RDATA     = 4'd8,
    ST_RD_MACK   = 4'd9
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;
  localparam logic       ACK_BIT          = 1'b0;
  localparam logic       NACK_BIT         = 1'b1;

  function automatic logic addr_match(input logic [7:0] dev_byte, input logic [6:0] addr);
    return dev_byte[7:1] == addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_cond.sv
// ============================================================================
// Module   : i2c_bus_cond
// Purpose  : Synchronizes SCL/SDA and flags SCL edges, START and STOP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_bus_cond (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       w_scl;
  logic       w_sda;

  // Reset to 1 so an idle bus never produces a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign w_scl      = scl_sync_q[1];
  assign w_sda      = sda_sync_q[1];
  assign sda_o      = w_sda;
  assign scl_rise_o = w_scl & ~scl_prev_q;
  assign scl_fall_o = ~w_scl & scl_prev_q;
  assign start_o    = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
  assign stop_o     = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_eeprom_slave_ctrl.sv
// ============================================================================
// Module   : i2c_eeprom_slave_ctrl
// Purpose  : I2C slave front end for an EEPROM: address/data reception and
//            sequential reads, driving an external address counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_eeprom_slave_ctrl
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] word_addr,
  output logic       addr_load,
  output logic       inc,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_bus_cond u_bus_cond (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (w_sda),
    .scl_rise_o (w_scl_rise),
    .scl_fall_o (w_scl_fall),
    .start_o    (w_start),
    .stop_o     (w_stop)
  );

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic       done_q;
  logic [7:0] shift_q;
  logic [7:0] rd_byte_q;
  logic       mack_q;
  logic       inc_pend_q;
  logic       sda_oe_q;
  logic [7:0] word_addr_q;
  logic [7:0] wr_data_q;
  logic       addr_load_q;
  logic       inc_q;
  logic       wr_en_q;
  logic       rd_req_q;
  logic       busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      done_q      <= 1'b0;
      shift_q     <= 8'h00;
      rd_byte_q   <= 8'h00;
      mack_q      <= NACK_BIT;
      inc_pend_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      word_addr_q <= 8'h00;
      wr_data_q   <= 8'h00;
      addr_load_q <= 1'b0;
      inc_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      addr_load_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
      inc_q       <= inc_pend_q;
      if (w_start) begin
        state_q   <= ST_DEV;
        bit_cnt_q <= 3'd0;
        done_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (w_stop) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        done_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_DEV, ST_WADDR, ST_WDATA: begin
            if (w_scl_rise) begin
              shift_q   <= {shift_q[6:0], w_sda};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) done_q <= 1'b1;
            end else if (w_scl_fall && done_q) begin
              done_q <= 1'b0;
              if (state_q == ST_DEV) begin
                sda_oe_q <= addr_match(shift_q, DEV_ADDR);
                state_q  <= ST_DEV_ACK;
              end else if (state_q == ST_WADDR) begin
                sda_oe_q    <= 1'b1;
                word_addr_q <= shift_q;
                addr_load_q <= 1'b1;
                state_q     <= ST_WADDR_ACK;
              end else begin
                sda_oe_q   <= 1'b1;
                wr_data_q  <= shift_q;
                wr_en_q    <= 1'b1;
                inc_pend_q <= 1'b1;
                state_q    <= ST_WDATA_ACK;
              end
            end
          end
          ST_DEV_ACK: begin
            if (!addr_match(shift_q, DEV_ADDR)) begin
              sda_oe_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else if (w_scl_fall) begin
              sda_oe_q <= 1'b0;
              if (shift_q[0]) begin
                rd_req_q <= 1'b1;
                state_q  <= ST_RD_LOAD;
              end else begin
                state_q  <= ST_WADDR;
              end
            end
          end
          ST_WADDR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WDATA;
            end
          end
          // rd_data is valid the cycle after rd_req, i.e. once rd_req_q has dropped.
          ST_RD_LOAD: begin
            if (!rd_req_q) begin
              rd_byte_q <= rd_data;
              sda_oe_q  <= ~rd_data[7];
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RDATA;
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) done_q <= 1'b1;
            end else if (w_scl_fall) begin
              if (done_q) begin
                done_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                inc_q    <= 1'b1;
                state_q  <= ST_RD_MACK;
              end else begin
                sda_oe_q <= ~rd_byte_q[3'd7 - bit_cnt_q];
              end
            end
          end
          ST_RD_MACK: begin
            if (w_scl_rise) begin
              mack_q <= w_sda;
            end else if (w_scl_fall) begin
              if (mack_q == ACK_BIT) begin
                rd_req_q <= 1'b1;
                state_q  <= ST_RD_LOAD;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign word_addr = word_addr_q;
  assign addr_load = addr_load_q;
  assign inc       = inc_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// ============================================================================
// Module   : tb_i2c_eeprom_slave_ctrl
// Purpose  : Directed bus-master bench for i2c_eeprom_slave_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_eeprom_slave_ctrl;

  localparam int QT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] word_addr;
  logic       addr_load;
  logic       inc;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave_ctrl #(.DEV_ADDR(7'b1010000)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .word_addr (word_addr),
    .addr_load (addr_load),
    .inc       (inc),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_al, n_wr, n_inc, n_rd, n_oe_hi, n_inc_late;
  int n_excl = 0;
  int n_oe_bad = 0;
  logic [7:0] wa_cap;
  logic [7:0] wr_cap [0:3];
  logic       wr_en_prev = 1'b0;
  logic       oe_prev    = 1'b0;
  logic       scl_prev   = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_counts;
    n_al = 0; n_wr = 0; n_inc = 0; n_rd = 0; n_oe_hi = 0; n_inc_late = 0;
    wa_cap = 8'h00;
    for (int i = 0; i < 4; i++) wr_cap[i] = 8'h00;
  endtask

  always @(negedge clk) begin
    if (addr_load) begin n_al++; wa_cap = word_addr; end
    if (wr_en) begin
      if (n_wr < 4) wr_cap[n_wr] = wr_data;
      n_wr++;
    end
    if (inc) n_inc++;
    if (rd_req) n_rd++;
    if (sda_oe) n_oe_hi++;
    if (int'(addr_load) + int'(inc) + int'(wr_en) + int'(rd_req) > 1) n_excl++;
    if (wr_en_prev && !inc) n_inc_late++;
    if (scl_m && scl_prev && (sda_oe != oe_prev)) n_oe_bad++;
    wr_en_prev = wr_en;
    oe_prev    = sda_oe;
    scl_prev   = scl_m;
  end

  task automatic i2c_start;
    sda_m = 1'b1; #QT; scl_m = 1'b1; #QT; sda_m = 1'b0; #QT; scl_m = 1'b0; #QT;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #QT; scl_m = 1'b1; #QT; sda_m = 1'b1; #QT;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #QT; scl_m = 1'b1; #(2*QT); scl_m = 1'b0; #QT;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #QT; scl_m = 1'b1; #QT; b = sda_line; #QT; scl_m = 1'b0; #QT;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rbyte;
    int         waited;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_data = 8'h00;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sda_oe",    sda_oe, 0);
    check_eq("rst_busy",      busy, 0);
    check_eq("rst_word_addr", word_addr, 8'h00);
    check_eq("rst_wr_data",   wr_data, 8'h00);
    check_eq("rst_pulses",    {addr_load, inc, wr_en, rd_req}, 4'b0000);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Write: A0, 35, 5A, C3
    clear_counts();
    i2c_start();
    put_byte(8'hA0, ack); check_eq("wr_ack_dev", ack, 0);
    put_byte(8'h35, ack); check_eq("wr_ack_addr", ack, 0);
    put_byte(8'h5A, ack); check_eq("wr_ack_d0", ack, 0);
    put_byte(8'hC3, ack); check_eq("wr_ack_d1", ack, 0);
    check_eq("wr_busy_before_stop", busy, 1);
    i2c_stop();
    #QT;
    check_eq("wr_busy_after_stop", busy, 0);
    check_eq("wr_addr_load_cnt", n_al, 1);
    check_eq("wr_word_addr", wa_cap, 8'h35);
    check_eq("wr_en_cnt", n_wr, 2);
    check_eq("wr_data0", wr_cap[0], 8'h5A);
    check_eq("wr_data1", wr_cap[1], 8'hC3);
    check_eq("wr_inc_cnt", n_inc, 2);
    check_eq("wr_inc_follow", n_inc_late, 0);

    // Address mismatch: A2
    clear_counts();
    i2c_start();
    put_byte(8'hA2, ack); check_eq("mm_nack", ack, 1);
    #QT;
    check_eq("mm_oe_never", n_oe_hi, 0);
    check_eq("mm_busy", busy, 0);
    check_eq("mm_pulses", n_al + n_wr + n_inc + n_rd, 0);
    check_eq("mm_word_addr_kept", word_addr, 8'h35);
    i2c_stop();

    // Random read: A0, 10, Sr, A1, read 96 (ACK), 3C (NACK)
    clear_counts();
    rd_data = 8'h96;
    i2c_start();
    put_byte(8'hA0, ack); check_eq("rd_ack_dev", ack, 0);
    put_byte(8'h10, ack); check_eq("rd_ack_addr", ack, 0);
    i2c_start();
    put_byte(8'hA1, ack); check_eq("rd_ack_devr", ack, 0);
    get_byte(rbyte);      check_eq("rd_byte0", rbyte, 8'h96);
    rd_data = 8'h3C;
    put_bit(1'b0);
    get_byte(rbyte);      check_eq("rd_byte1", rbyte, 8'h3C);
    put_bit(1'b1);
    #QT;
    check_eq("rd_busy_idle", busy, 0);
    check_eq("rd_req_cnt", n_rd, 2);
    check_eq("rd_inc_cnt", n_inc, 2);
    check_eq("rd_addr_load_cnt", n_al, 1);
    check_eq("rd_word_addr", wa_cap, 8'h10);
    check_eq("rd_no_wr", n_wr, 0);
    i2c_stop();

    // STOP after 4 bits of a data byte
    clear_counts();
    i2c_start();
    put_byte(8'hA0, ack); check_eq("ps_ack_dev", ack, 0);
    put_byte(8'h44, ack); check_eq("ps_ack_addr", ack, 0);
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_stop();
    #QT;
    check_eq("ps_wr_en_cnt", n_wr, 0);
    check_eq("ps_inc_cnt", n_inc, 0);
    check_eq("ps_sda_oe", sda_oe, 0);
    check_eq("ps_busy", busy, 0);
    check_eq("ps_word_addr", word_addr, 8'h44);

    // Reset while driving a read bit of 0
    clear_counts();
    rd_data = 8'h55;
    i2c_start();
    put_byte(8'hA0, ack);
    put_byte(8'h22, ack);
    i2c_start();
    put_byte(8'hA1, ack); check_eq("rs_ack_devr", ack, 0);
    waited = 0;
    while (!sda_oe && waited < 30) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check_eq("rs_driving_zero", sda_oe, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("rs_sda_oe_async", sda_oe, 0);
    check_eq("rs_busy", busy, 0);
    check_eq("rs_word_addr", word_addr, 8'h00);
    check_eq("rs_wr_data", wr_data, 8'h00);
    check_eq("rs_pulses_now", {addr_load, inc, wr_en, rd_req}, 4'b0000);
    clear_counts();
    repeat (4) @(posedge clk);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("rs_pulses_after", n_al + n_wr + n_inc + n_rd, 0);
    check_eq("rs_busy_after", busy, 0);
    check_eq("rs_oe_after", n_oe_hi, 0);

    check_eq("excl_pulses", n_excl, 0);
    check_eq("oe_scl_high", n_oe_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_eeprom_slave_ctrl.md
I2C_EEPROM_SLAVE_CTRL -- requirements
Module: i2c_eeprom_slave_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1010000, is the 7-bit I2C device address this slave answers to.
REQ-002 clk  in  1  system clock; every flop in the block is on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 scl_in  in  1  raw I2C clock line (asynchronous to clk).
REQ-005 sda_in  in  1  raw I2C data line (asynchronous to clk).
REQ-006 sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 word_addr  out  8  word address byte received from the master; held until the next address byte.
REQ-008 addr_load  out  1  one-clk pulse: word_addr is valid; the address counter loads it.
REQ-009 inc  out  1  one-clk pulse: the address counter advances by 1.
REQ-010 wr_en  out  1  one-clk pulse: wr_data is to be written at the current address.
REQ-011 wr_data  out  8  data byte received from the master.
REQ-012 rd_req  out  1  one-clk pulse: a read byte is requested from the current address.
REQ-013 rd_data  in  8  read byte; valid on the clk cycle after rd_req.
REQ-014 busy  out  1  high from START until STOP, or until return to IDLE.

Function
REQ-015 scl_in and sda_in SHALL each pass a 2-flop synchronizer; all edge detection uses the synchronized values.
REQ-016 START is an SDA fall while SCL is high; STOP is an SDA rise while SCL is high. Both SHALL be detected in any state.
REQ-017 SDA SHALL be sampled on a detected SCL rise; sda_oe SHALL change only on a detected SCL fall, or on START/STOP.
REQ-018 FSM states and transitions:
- IDLE: on START, go to DEV.
- DEV: shift in 8 bits, MSB first.
- DEV_ACK: on address match, drive ACK and go to WADDR (R/W=0) or RD_LOAD (R/W=1); on mismatch, go to IDLE with sda_oe=0.
- WADDR: receive 8 bits.
- WADDR_ACK: drive ACK, then go to WDATA.
- WDATA: receive 8 bits.
- WDATA_ACK: drive ACK, then return to WDATA.
- RD_LOAD: capture rd_data, then go to RDATA.
- RDATA: drive 8 bits, MSB first.
- RD_MACK: sample the master's ACK/NACK.
REQ-019 Each ACK bit SHALL assert sda_oe from the SCL fall after bit 8 until the SCL fall after the ACK clock.
REQ-020 addr_load SHALL pulse once, at entry to WADDR_ACK; word_addr SHALL update in the same cycle.
REQ-021 wr_en SHALL pulse at entry to WDATA_ACK with wr_data valid; inc SHALL pulse exactly one clk after that wr_en.
REQ-022 rd_req SHALL pulse at entry to RD_LOAD; the byte SHALL be latched one clk later.
REQ-023 In RDATA, bit n SHALL be driven as sda_oe = ~byte[n], changed on each SCL fall.
REQ-024 In RD_MACK, inc SHALL pulse once; ACK (SDA=0) goes to RD_LOAD; NACK goes to IDLE.
REQ-025 A repeated START in any state SHALL go to DEV, release sda_oe and leave word_addr unchanged.
REQ-026 STOP in any state SHALL go to IDLE with sda_oe=0; a partial byte is discarded, with no wr_en and no inc.
REQ-027 addr_load, inc, wr_en and rd_req SHALL be mutually exclusive in any clk cycle.
REQ-028 The bit counter is 3 bits and SHALL wrap from 7 to 0 at each byte boundary; address wrap is owned by the counter block.

Reset
REQ-029 On reset: state=IDLE, sda_oe=0, addr_load=inc=wr_en=rd_req=0, busy=0, word_addr=0, wr_data=0, synchronizers=1 (bus idle).
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); no pulse SHALL be emitted during or after reset.

Structure
REQ-031 The FSM state enum, DEV_ADDR default and ACK/NACK constants SHALL live in a shared package, i2c_eeprom_pkg.
REQ-032 Synchronizers and SCL-rise/SCL-fall/START/STOP detection SHALL form one sub-module, i2c_bus_cond.

Verification
REQ-033 Write: START, 0xA0, 0x35, 0x5A, 0xC3, STOP -> 4 ACKs; addr_load with word_addr=0x35; wr_en 0x5A then 0xC3, each followed by inc; busy drops after STOP.
REQ-034 Address mismatch: START, 0xA2 -> no ACK (sda_oe stays 0), FSM in IDLE, no pulses.
REQ-035 Random read: START, 0xA0, 0x10, repeated START, 0xA1, with rd_data=0x96 then 0x3C; master ACK then NACK -> SDA carries 0x96 then 0x3C; rd_req x2; inc x2; FSM returns to IDLE.
REQ-036 STOP after 4 bits of a data byte -> no wr_en, no inc, sda_oe=0.
REQ-037 Reset asserted while driving a read bit of 0 -> sda_oe=0 within the same clk cycle; all outputs at reset values.
